// File: rtl/conv_layer_sequencer_if.sv
// Handshake and address bundle between the layer sequencer and its surroundings:
// kernel memory, feature-map memory, conv engine and partial-sum accumulator.
interface conv_layer_sequencer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  i_start;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;
  logic                  o_kernel_load;
  logic [ADDR_WIDTH-1:0] o_kernel_addr;
  logic                  o_pix_rd;
  logic [ADDR_WIDTH-1:0] o_pix_addr;
  logic                  o_conv_valid;
  logic                  i_conv_valid;
  logic                  o_acc_en;
  logic                  o_acc_first;
  logic                  o_acc_last;
  logic [ADDR_WIDTH-1:0] o_out_addr;
  logic [ADDR_WIDTH-1:0] o_oc;

  modport master (
    input  i_start, i_conv_valid,
    output o_busy, o_done, o_error, o_kernel_load, o_kernel_addr, o_pix_rd,
           o_pix_addr, o_conv_valid, o_acc_en, o_acc_first, o_acc_last,
           o_out_addr, o_oc
  );

  modport slave (
    output i_start, i_conv_valid,
    input  o_busy, o_done, o_error, o_kernel_load, o_kernel_addr, o_pix_rd,
           o_pix_addr, o_conv_valid, o_acc_en, o_acc_first, o_acc_last,
           o_out_addr, o_oc
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Walks one conv3x3 engine through every (output channel, input channel) pass of a
// layer: kernel load, padded-image stream, result tagging for the partial-sum accumulator.
module conv_layer_sequencer #(
  parameter int IMAGE_WIDTH   = 5,
  parameter int IN_CHANNELS   = 3,
  parameter int OUT_CHANNELS  = 4,
  parameter int ADDR_WIDTH    = 16,
  parameter int KERNEL_LAT    = 1,
  parameter int DRAIN_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,   // active-high despite the name
  conv_layer_sequencer_if.master bus
);
  localparam int N       = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int TIMER_W = $clog2(DRAIN_TIMEOUT + KERNEL_LAT + N + 2) + 1;
  localparam logic [ADDR_WIDTH-1:0] N_A     = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] IC_A    = ADDR_WIDTH'(IN_CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] OC_A    = ADDR_WIDTH'(OUT_CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [TIMER_W-1:0]    KL_LAST = TIMER_W'(KERNEL_LAT - 1);
  localparam logic [TIMER_W-1:0]    DT_T    = TIMER_W'(DRAIN_TIMEOUT);
  localparam logic [TIMER_W-1:0]    ONE_T   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0]    TWO_T   = TIMER_W'(2);

  typedef enum logic [2:0] {IDLE, LOAD_K, KWAIT, STREAM, DRAIN, NEXT, DONE, ERROR} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] oc_reg, oc_next;
  logic [ADDR_WIDTH-1:0] ic_reg, ic_next;
  logic [ADDR_WIDTH-1:0] p_reg, p_next;
  logic [ADDR_WIDTH-1:0] out_cnt_reg, out_cnt_next;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic                  error_reg, error_next;
  logic                  pix_rd_d_reg;

  logic acc_win, acc_en, pix_rd, busy;

  assign acc_win = (state_reg == STREAM) || (state_reg == DRAIN);
  assign acc_en  = bus.i_conv_valid && acc_win && (out_cnt_reg != N_A);
  assign pix_rd  = (state_reg == STREAM);
  assign busy    = (state_reg == LOAD_K) || (state_reg == KWAIT) || (state_reg == STREAM) ||
                   (state_reg == DRAIN)  || (state_reg == NEXT);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg    <= IDLE;
      oc_reg       <= '0;
      ic_reg       <= '0;
      p_reg        <= '0;
      out_cnt_reg  <= '0;
      timer_reg    <= '0;
      error_reg    <= 1'b0;
      pix_rd_d_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      oc_reg       <= oc_next;
      ic_reg       <= ic_next;
      p_reg        <= p_next;
      out_cnt_reg  <= out_cnt_next;
      timer_reg    <= timer_next;
      error_reg    <= error_next;
      pix_rd_d_reg <= pix_rd;
    end
  end

  always_comb begin
    state_next   = state_reg;
    oc_next      = oc_reg;
    ic_next      = ic_reg;
    p_next       = p_reg;
    out_cnt_next = out_cnt_reg;
    timer_next   = timer_reg;
    error_next   = error_reg;

    // Results are counted and the idle timer runs across both STREAM and DRAIN,
    // so an engine that stalls early is timed from its last real output.
    if (acc_en) out_cnt_next = out_cnt_reg + ONE_A;
    if (acc_win) timer_next = bus.i_conv_valid ? '0 : timer_reg + ONE_T;

    case (state_reg)
      IDLE: begin
        if (bus.i_start) begin
          error_next = 1'b0;
          oc_next    = '0;
          ic_next    = '0;
          state_next = LOAD_K;
        end
      end
      LOAD_K: begin
        timer_next = '0;
        state_next = KWAIT;
      end
      KWAIT: begin
        timer_next = timer_reg + ONE_T;
        if (timer_reg == KL_LAST) begin
          p_next       = '0;
          out_cnt_next = '0;
          timer_next   = '0;
          state_next   = STREAM;
        end
      end
      STREAM: begin
        if (p_reg == N_A - ONE_A) state_next = DRAIN;
        else                      p_next = p_reg + ONE_A;
      end
      DRAIN: begin
        // ERROR lands exactly DRAIN_TIMEOUT cycles after the last engine valid.
        if (out_cnt_next == N_A) begin
          state_next = NEXT;
        end else if (!bus.i_conv_valid && (timer_reg + TWO_T >= DT_T)) begin
          error_next = 1'b1;
          state_next = ERROR;
        end
      end
      NEXT: begin
        if (ic_reg < IC_A - ONE_A) begin
          ic_next    = ic_reg + ONE_A;
          state_next = LOAD_K;
        end else if (oc_reg == OC_A - ONE_A) begin
          ic_next    = '0;
          oc_next    = '0;
          state_next = DONE;
        end else begin
          ic_next    = '0;
          oc_next    = oc_reg + ONE_A;
          state_next = LOAD_K;
        end
      end
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.o_busy        = busy;
  assign bus.o_done        = (state_reg == DONE);
  assign bus.o_error       = error_reg;
  assign bus.o_kernel_load = (state_reg == LOAD_K);
  assign bus.o_kernel_addr = oc_reg * IC_A + ic_reg;
  assign bus.o_pix_rd      = pix_rd;
  assign bus.o_pix_addr    = ic_reg * N_A + p_reg;
  assign bus.o_conv_valid  = pix_rd_d_reg;
  assign bus.o_acc_en      = acc_en;
  // Tags are masked while idle so a reset sequencer drives nothing but zeros.
  assign bus.o_acc_first   = busy && (ic_reg == '0);
  assign bus.o_acc_last    = busy && (ic_reg == IC_A - ONE_A);
  assign bus.o_out_addr    = oc_reg * N_A + out_cnt_reg;
  assign bus.o_oc          = oc_reg;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench: a randomized-latency engine model feeds the sequencer and every
// logged event is compared against sequences computed from the layer's loop nest.
module tb_conv_layer_sequencer;
  localparam int IW = 5, IC = 3, OC = 2, AW = 16, KL = 1, DT = 1023;
  localparam int N  = IW * IW;

  typedef struct packed {
    logic          first;
    logic          last;
    logic [AW-1:0] oc;
    logic [AW-1:0] addr;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_layer_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  conv_layer_sequencer #(
    .IMAGE_WIDTH(IW), .IN_CHANNELS(IC), .OUT_CHANNELS(OC),
    .ADDR_WIDTH(AW), .KERNEL_LAT(KL), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [AW-1:0] kq[$];
  logic [AW-1:0] pq[$];
  int kcq[$], pcq[$], ccq[$];
  acc_t aq[$];
  acc_t a_mon;
  int done_cnt = 0, last_acc_cyc = 0, err_cyc = 0, err_rises = 0;
  logic err_busy = 1'b0, err_prev = 1'b0;
  int eng_lat = 0, eng_limit = -1;
  bit eng_force = 1'b0, eng_extra = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event logger, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_kernel_load) begin kq.push_back(bus.o_kernel_addr); kcq.push_back(cyc); end
      if (bus.o_pix_rd) begin pq.push_back(bus.o_pix_addr); pcq.push_back(cyc); end
      if (bus.o_conv_valid) ccq.push_back(cyc);
      if (bus.o_acc_en) begin
        a_mon = '{first: bus.o_acc_first, last: bus.o_acc_last, oc: bus.o_oc, addr: bus.o_out_addr};
        aq.push_back(a_mon);
        last_acc_cyc = cyc;
        check("acc_en_only_while_busy", 64'(bus.o_busy), 64'(1));
      end
      if (bus.o_done) done_cnt++;
      if (bus.o_error && !err_prev) begin
        err_cyc   = cyc;
        err_busy  = bus.o_busy;
        err_rises++;
      end
      err_prev = bus.o_error;
    end
  end

  // Engine model: echoes o_conv_valid after eng_lat cycles, optionally capped per pass,
  // plus forced and post-pass stray valids.
  initial begin
    logic [7:0] hist;
    int ecnt;
    bit ext_pend, real_v;
    hist = '0; ecnt = 0; ext_pend = 1'b0;
    bus.i_conv_valid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.o_kernel_load) ecnt = 0;
      hist   = {hist[6:0], bus.o_conv_valid};
      real_v = hist[eng_lat] && (eng_limit < 0 || ecnt < eng_limit);
      if (real_v) ecnt++;
      bus.i_conv_valid = real_v || eng_force || ext_pend;
      ext_pend = eng_extra && real_v && (ecnt == N);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    kq.delete(); pq.delete(); kcq.delete(); pcq.delete(); ccq.delete(); aq.delete();
    done_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},        64'(bus.o_busy),        64'(0));
    check({tag, "_done"},        64'(bus.o_done),        64'(0));
    check({tag, "_error"},       64'(bus.o_error),       64'(0));
    check({tag, "_kernel_load"}, 64'(bus.o_kernel_load), 64'(0));
    check({tag, "_kernel_addr"}, 64'(bus.o_kernel_addr), 64'(0));
    check({tag, "_pix_rd"},      64'(bus.o_pix_rd),      64'(0));
    check({tag, "_pix_addr"},    64'(bus.o_pix_addr),    64'(0));
    check({tag, "_conv_valid"},  64'(bus.o_conv_valid),  64'(0));
    check({tag, "_acc_en"},      64'(bus.o_acc_en),      64'(0));
    check({tag, "_acc_first"},   64'(bus.o_acc_first),   64'(0));
    check({tag, "_acc_last"},    64'(bus.o_acc_last),    64'(0));
    check({tag, "_out_addr"},    64'(bus.o_out_addr),    64'(0));
    check({tag, "_oc"},          64'(bus.o_oc),          64'(0));
  endtask

  task automatic start_layer();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(bus.o_busy), 64'(1));
  endtask

  task automatic wait_done(input int budget, input bit rand_starts);
    int n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (done_cnt != 0) break;
      if (rand_starts) bus.i_start = ($urandom_range(0, 5) == 0);
    end
    bus.i_start = 1'b0;
    check("done_within_budget", 64'(done_cnt != 0), 64'(1));
  endtask

  // Expected events come straight from the layer's loop nest.
  task automatic compare_layer();
    logic [AW-1:0] ek[$];
    logic [AW-1:0] ep[$];
    acc_t ea[$];
    int idx;
    for (int o = 0; o < OC; o++)
      for (int i = 0; i < IC; i++) begin
        ek.push_back(AW'(o * IC + i));
        for (int j = 0; j < N; j++) begin
          ep.push_back(AW'(i * N + j));
          ea.push_back('{first: (i == 0), last: (i == IC - 1), oc: AW'(o), addr: AW'(o * N + j)});
        end
      end
    check("kernel_load_count", 64'(kq.size()), 64'(ek.size()));
    check("pix_rd_count",      64'(pq.size()), 64'(ep.size()));
    check("conv_valid_count",  64'(ccq.size()), 64'(ep.size()));
    check("acc_en_count",      64'(aq.size()), 64'(ea.size()));
    for (int k = 0; k < kq.size() && k < ek.size(); k++) check("kernel_addr", 64'(kq[k]), 64'(ek[k]));
    for (int k = 0; k < pq.size() && k < ep.size(); k++) check("pix_addr", 64'(pq[k]), 64'(ep[k]));
    for (int k = 0; k < aq.size() && k < ea.size(); k++) check("acc_tag", 64'(aq[k]), 64'(ea[k]));
    for (int k = 0; k < kcq.size() && k < OC * IC; k++)
      for (int p = 0; p < N; p++) begin
        idx = k * N + p;
        if (idx < pcq.size()) check("pix_rd_timing", 64'(pcq[idx]), 64'(kcq[k] + 1 + KL + p));
        if (idx < ccq.size()) check("conv_valid_timing", 64'(ccq[idx]), 64'(kcq[k] + 2 + KL + p));
      end
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("error_clear_after_layer", 64'(bus.o_error), 64'(0));
    check("busy_clear_after_layer", 64'(bus.o_busy), 64'(0));
  endtask

  initial begin
    bus.i_start = 1'b1;
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_zero("in_reset");
    tick();
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clk);
    check_zero("after_reset");

    // Stray engine valid while idle.
    tick();
    eng_force = 1'b1;
    @(negedge clk);
    check("idle_valid_no_acc", 64'(bus.o_acc_en), 64'(0));
    tick();
    eng_force = 1'b0;
    repeat (3) tick();

    // Full layers; the second adds a stray valid in every NEXT cycle.
    for (int run = 0; run < 2; run++) begin
      eng_lat   = $urandom_range(0, 4);
      eng_extra = (run == 1);
      clear_log();
      start_layer();
      wait_done(600, 1'b1);
      compare_layer();
      $display("layer run %0d: engine latency %0d, %0d kernel loads, %0d acc writes",
               run, eng_lat, kq.size(), aq.size());
      repeat (4) tick();
    end
    eng_extra = 1'b0;

    // Engine stalls after 10 results.
    eng_lat   = $urandom_range(0, 4);
    eng_limit = 10;
    clear_log();
    err_rises = 0;
    start_layer();
    for (int n = 0; n < 1300 && err_rises == 0; n++) tick();
    check("timeout_seen", 64'(err_rises), 64'(1));
    check("timeout_distance", 64'(err_cyc - last_acc_cyc), 64'(DT));
    check("timeout_busy_low", 64'(err_busy), 64'(0));
    check("timeout_acc_count", 64'(aq.size()), 64'(10));
    repeat (3) tick();
    @(negedge clk);
    check("error_sticky", 64'(bus.o_error), 64'(1));
    check("error_not_busy", 64'(bus.o_busy), 64'(0));
    $display("timeout run: latency %0d, error %0d cycles after last valid", eng_lat, err_cyc - last_acc_cyc);
    eng_limit = -1;
    clear_log();
    tick();
    start_layer();
    check("error_cleared_by_start", 64'(bus.o_error), 64'(0));
    wait_done(600, 1'b0);
    compare_layer();
    $display("restart after timeout: %0d kernel loads, %0d acc writes", kq.size(), aq.size());
    repeat (4) tick();

    // Reset in the middle of the first pass's stream.
    clear_log();
    start_layer();
    begin
      bit found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
        @(negedge clk);
        if (bus.o_pix_rd && bus.o_pix_addr == AW'(12)) found = 1'b1;
      end
      check("reached_p12", 64'(found), 64'(1));
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("mid_stream_reset");
    tick();
    rst_n = 1'b0;
    repeat (10) tick();
    eng_lat = $urandom_range(0, 4);
    clear_log();
    start_layer();
    wait_done(600, 1'b1);
    compare_layer();
    $display("restart after reset: latency %0d, first kernel addr %0d, first pix addr %0d",
             eng_lat, (kq.size() > 0) ? kq[0] : 16'hffff, (pq.size() > 0) ? pq[0] : 16'hffff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
